// File: rtl/shift_add_mult.sv
// Iterative shift-and-add multiplier: one product bit per cycle, fixed WIDTH-cycle latency.
// Define SHIFT_ADD_MULT_SIGNED_EN for two's-complement operands and product.
module shift_add_mult #(
    parameter int WIDTH = 28
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_reg;
    logic [WIDTH-1:0]     mcand_reg;
    logic [2*WIDTH-1:0]   acc_reg;
    logic [CW-1:0]        count_reg;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH:0]       upper_sum;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   result;

`ifdef SHIFT_ADD_MULT_SIGNED_EN
    logic sgn_reg;

    // |-2^(WIDTH-1)| = 2^(WIDTH-1) still fits as an unsigned WIDTH-bit magnitude.
    assign a_mag  = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign b_mag  = b[WIDTH-1] ? (~b + 1'b1) : b;
    assign result = sgn_reg ? (~acc_next + 1'b1) : acc_next;
`else
    assign a_mag  = a;
    assign b_mag  = b;
    assign result = acc_next;
`endif

    // Upper half gains a carry bit; the shift folds it back into the accumulator.
    assign upper_sum = acc_reg[0] ? ({1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, mcand_reg})
                                  :  {1'b0, acc_reg[2*WIDTH-1:WIDTH]};
    assign acc_next  = {upper_sum, acc_reg[WIDTH-1:1]};

    assign in_ready = (state_reg == IDLE) && rstn;
    assign busy     = (state_reg != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            mcand_reg <= '0;
            acc_reg   <= '0;
            count_reg <= '0;
            p         <= '0;
            out_valid <= 1'b0;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
            sgn_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        mcand_reg <= a_mag;
                        acc_reg   <= {{WIDTH{1'b0}}, b_mag};
                        count_reg <= '0;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
                        sgn_reg   <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    acc_reg   <= acc_next;
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == LAST_STEP) begin
                        p         <= result;
                        out_valid <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
